// File: rtl/prbs_pkg.sv
// Shared types and helpers for the PRBS31 (x^31 + x^28 + 1) receive checker.
package prbs_pkg;

  localparam int PRBS_LEN = 31;
  localparam int TAP_A    = 30;
  localparam int TAP_B    = 27;
  localparam int POP_W    = 6;

  typedef enum logic [1:0] {IDLE, HUNT, LOCKED} chk_state_t;

  typedef struct packed {
    logic [PRBS_LEN-1:0] state;
    logic [PRBS_LEN-1:0] word;
  } prbs_step_t;

  // Advances the LFSR by width bits; the first generated bit lands at word[width-1].
  function automatic prbs_step_t prbs31_step(input logic [PRBS_LEN-1:0] state, input int width);
    prbs_step_t r;
    logic       b;
    r.state = state;
    r.word  = '0;
    for (int k = 0; k < PRBS_LEN; k++) begin
      if (k < width) begin
        b       = r.state[TAP_A] ^ r.state[TAP_B];
        r.state = {r.state[PRBS_LEN-2:0], b};
        r.word  = {r.word[PRBS_LEN-2:0], b};
      end
    end
    return r;
  endfunction

  function automatic logic [POP_W-1:0] popcount(input logic [PRBS_LEN-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < PRBS_LEN; i++) n = n + POP_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Statistics counter that adds a variable amount per event and clamps at all-ones.
module sat_counter
  import prbs_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int AMT_W = POP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc_en,
  input  logic [AMT_W-1:0] inc_amt,
  output logic [CNT_W-1:0] cnt
);

  localparam int SUM_W = ((CNT_W > AMT_W) ? CNT_W : AMT_W) + 1;
  localparam logic [SUM_W-1:0] MAX = SUM_W'({CNT_W{1'b1}});

  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    sum     = SUM_W'(cnt) + SUM_W'(inc_amt);
    cnt_nxt = (sum > MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  end

  // NOTE: reset is synchronous (sampled on the clock edge, not in the sensitivity list),
  // and state registers use non-blocking <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (inc_en) cnt <= cnt_nxt;
  end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS31 checker: hunts for the sequence, locks, then flywheels
// the LFSR and counts bit errors and checked beats.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int CNT_W      = 32,
  parameter int LOCK_BEATS = 4,
  parameter int LOSS_BEATS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr_cnt,
  input  logic             din_vld,
  input  logic [WIDTH-1:0] din,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] beat_cnt
);

  localparam int FILL   = (PRBS_LEN + WIDTH - 1) / WIDTH;
  localparam int FILL_W = $clog2(FILL + 1);
  localparam int LOCK_W = $clog2(LOCK_BEATS + 1);
  localparam int LOSS_W = $clog2(LOSS_BEATS + 1);
  localparam logic [FILL_W-1:0] FILL_C    = FILL_W'(FILL);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_BEATS - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_BEATS - 1);

  chk_state_t          state_q, state_d;
  logic [PRBS_LEN-1:0] s_q, s_d, s_rx, diff;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [LOCK_W-1:0]   match_q, match_d;
  logic [LOSS_W-1:0]   loss_q, loss_d;
  logic                err_pulse_q, err_pulse_d;
  logic                inc_beat, inc_err, beat_match;
  logic [POP_W-1:0]    pop;
  prbs_step_t          step;

  always_comb begin
    step       = prbs31_step(s_q, WIDTH);
    diff       = PRBS_LEN'(din) ^ step.word;
    beat_match = (diff == '0);
    pop        = popcount(diff);
    s_rx       = (s_q << WIDTH) | PRBS_LEN'(din);
  end

  // NOTE: every signal written here gets a default first, so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    fill_d      = fill_q;
    match_d     = match_q;
    loss_d      = loss_q;
    err_pulse_d = 1'b0;
    inc_beat    = 1'b0;
    inc_err     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d = HUNT;
          fill_d  = '0;
          match_d = '0;
        end
      end
      HUNT: begin
        if (din_vld) begin
          s_d = s_rx;
          if (fill_q < FILL_C) begin
            fill_d = fill_q + 1'b1;
          end else if (beat_match && (s_q != '0)) begin
            // An all-zero register predicts all-zero data, so a stuck-0 line never locks.
            if (match_q == LOCK_LAST) begin
              state_d = LOCKED;
              match_d = '0;
              loss_d  = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            match_d = '0;
          end
        end
      end
      LOCKED: begin
        if (din_vld) begin
          s_d      = step.state;
          inc_beat = 1'b1;
          inc_err  = 1'b1;
          if (!beat_match) begin
            err_pulse_d = 1'b1;
            if (loss_q == LOSS_LAST) begin
              state_d = HUNT;
              fill_d  = '0;
              match_d = '0;
            end else begin
              loss_d = loss_q + 1'b1;
            end
          end else begin
            loss_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!en) begin
      state_d     = IDLE;
      s_d         = s_q;
      fill_d      = fill_q;
      match_d     = match_q;
      loss_d      = loss_q;
      err_pulse_d = 1'b0;
      inc_beat    = 1'b0;
      inc_err     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s_q         <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      loss_q      <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      loss_q      <= loss_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W), .AMT_W(POP_W)) u_err_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr_cnt),
    .inc_en  (inc_err),
    .inc_amt (pop),
    .cnt     (err_cnt)
  );

  sat_counter #(.CNT_W(CNT_W), .AMT_W(POP_W)) u_beat_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr_cnt),
    .inc_en  (inc_beat),
    .inc_amt (POP_W'(1)),
    .cnt     (beat_cnt)
  );

  assign locked    = (state_q == LOCKED);
  assign err_pulse = err_pulse_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: a 32-bit-counter instance and a 4-bit-counter
// instance share one stimulus stream.
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        rst, en, clr_cnt, din_vld;
  logic [7:0]  din;
  logic        locked, err_pulse, locked4, err_pulse4;
  logic [31:0] err_cnt, beat_cnt;
  logic [3:0]  err_cnt4, beat_cnt4;

  int          total = 0;
  int          bad   = 0;
  int          run;
  logic [30:0] g;
  logic [7:0]  w;

  localparam logic [30:0] SEED = 31'h1234_5678;

  always #5 clk = ~clk;

  prbs_checker #(.WIDTH(8), .CNT_W(32), .LOCK_BEATS(4), .LOSS_BEATS(8)) dut (
    .clk(clk), .rst(rst), .en(en), .clr_cnt(clr_cnt), .din_vld(din_vld), .din(din),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .beat_cnt(beat_cnt)
  );

  prbs_checker #(.WIDTH(8), .CNT_W(4), .LOCK_BEATS(4), .LOSS_BEATS(8)) dut4 (
    .clk(clk), .rst(rst), .en(en), .clr_cnt(clr_cnt), .din_vld(din_vld), .din(din),
    .locked(locked4), .err_pulse(err_pulse4), .err_cnt(err_cnt4), .beat_cnt(beat_cnt4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference pattern source: one 8-bit word, earliest bit in the MSB.
  task automatic gen(output logic [7:0] word);
    logic b;
    word = '0;
    for (int k = 0; k < 8; k++) begin
      b    = g[30] ^ g[27];
      g    = {g[29:0], b};
      word = {word[6:0], b};
    end
  endtask

  task automatic beat(input logic [7:0] d);
    din     = d;
    din_vld = 1'b1;
    step();
  endtask

  task automatic bubble();
    din     = 8'($urandom);
    din_vld = 1'b0;
    step();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_pulse"},  32'(err_pulse), 32'd0);
    check({tag, "_err"},    err_cnt, 32'd0);
    check({tag, "_beat"},   beat_cnt, 32'd0);
  endtask

  initial begin
    // Reset held with valid random data.
    rst = 1'b1; en = 1'b1; clr_cnt = 1'b0; din_vld = 1'b1; din = 8'($urandom);
    step(); check_idle_outputs("rst_c1");
    din = 8'($urandom);
    step(); check_idle_outputs("rst_c2");
    rst = 1'b0;
    bubble(); check_idle_outputs("rst_after");

    // Clean lock: 4 fill beats plus 4 matching beats.
    g = SEED;
    for (int i = 1; i <= 8; i++) begin
      gen(w); beat(w);
      check("lock_idx", 32'(locked), 32'(i == 8));
    end
    for (int i = 0; i < 100; i++) begin
      gen(w); beat(w);
    end
    check("clean_beat_cnt", beat_cnt, 32'd100);
    check("clean_err_cnt", err_cnt, 32'd0);
    check("clean_beat_cnt4", 32'(beat_cnt4), 32'hF);

    // Error injection: 1 bit, then 3 bits.
    gen(w); beat(w ^ 8'h01);
    check("inj1_pulse", 32'(err_pulse), 32'd1);
    for (int i = 0; i < 3; i++) begin
      gen(w); beat(w);
      check("inj_gap_pulse", 32'(err_pulse), 32'd0);
    end
    gen(w); beat(w ^ 8'h92);
    check("inj3_pulse", 32'(err_pulse), 32'd1);
    gen(w); beat(w);
    check("inj_end_pulse", 32'(err_pulse), 32'd0);
    check("inj_err_cnt", err_cnt, 32'd4);
    check("inj_err_cnt4", 32'(err_cnt4), 32'd4);
    check("inj_locked", 32'(locked), 32'd1);

    // Loss: all-zero input; a predicted zero word would count as a match.
    run = 0;
    for (int i = 0; i < 40 && run < 8; i++) begin
      gen(w); beat(8'h00);
      if (w != 8'h00) run++;
      else run = 0;
      check("loss_locked", 32'(locked), 32'(run < 8));
      check("loss_pulse", 32'(err_pulse), 32'(w != 8'h00));
    end
    for (int i = 0; i < 20; i++) begin
      beat(8'h00);
      check("stuck0_nolock", 32'(locked), 32'd0);
    end
    for (int i = 1; i <= 8; i++) begin
      gen(w); beat(w);
      check("relock_idx", 32'(locked), 32'(i == 8));
    end

    // Reset mid-lock, then the clean stream again with bubbles.
    rst = 1'b1; gen(w); beat(w);
    check_idle_outputs("rst_mid");
    rst = 1'b0;
    bubble();
    g = SEED;
    for (int i = 1; i <= 8; i++) begin
      gen(w); beat(w);
      check("bub_lock_idx", 32'(locked), 32'(i == 8));
      bubble();
      check("bub_hold_lock", 32'(locked), 32'(i == 8));
    end
    for (int i = 0; i < 10; i++) begin
      gen(w); beat(w); bubble();
    end
    check("bub_beat_cnt", beat_cnt, 32'd10);
    check("bub_err_cnt", err_cnt, 32'd0);
    gen(w); beat(w ^ 8'h10);
    check("bub_err_pulse", 32'(err_pulse), 32'd1);
    bubble();
    check("bub_idle_pulse", 32'(err_pulse), 32'd0);
    check("bub_idle_err", err_cnt, 32'd1);
    check("bub_idle_beat", beat_cnt, 32'd11);

    // Counter clear and saturation.
    clr_cnt = 1'b1; gen(w); beat(w);
    clr_cnt = 1'b0;
    check("clr_err_cnt", err_cnt, 32'd0);
    check("clr_beat_cnt", beat_cnt, 32'd0);
    gen(w); beat(w ^ 8'hFF);
    check("sat_step1", 32'(err_cnt4), 32'd8);
    gen(w); beat(w);
    gen(w); beat(w ^ 8'hFF);
    check("sat_step2", 32'(err_cnt4), 32'hF);
    gen(w); beat(w);
    gen(w); beat(w ^ 8'h0F);
    check("sat_err_cnt4", 32'(err_cnt4), 32'hF);
    check("sat_err_cnt", err_cnt, 32'd20);
    check("sat_beat_cnt", beat_cnt, 32'd5);
    check("sat_locked", 32'(locked4), 32'd1);
    clr_cnt = 1'b1; gen(w); beat(w ^ 8'hFF);
    clr_cnt = 1'b0;
    check("clr_win_err", err_cnt, 32'd0);
    check("clr_win_err4", 32'(err_cnt4), 32'd0);
    check("clr_win_pulse", 32'(err_pulse4), 32'd1);

    // Disable with a valid error beat: beat ignored, counters hold.
    en = 1'b0; gen(w); beat(w ^ 8'hFF);
    check("dis_locked", 32'(locked), 32'd0);
    check("dis_pulse", 32'(err_pulse), 32'd0);
    check("dis_err_hold", err_cnt, 32'd0);
    check("dis_beat_hold", beat_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Receive-side PRBS31 checker for the verification environment. It consumes a WIDTH-bit parallel data stream, self-synchronises to it, declares lock, and counts bit errors and checked beats afterwards.
- It is the reader counterpart of the pattern source that drives DUT data inputs. It sits at a DUT output, or after a capture register, in tb_top.

Parameters:
- WIDTH, 8, bits per beat; legal range 1..31.
- CNT_W, 32, width of both statistics counters.
- LOCK_BEATS, 4, consecutive matching beats needed to lock.
- LOSS_BEATS, 8, consecutive mismatching beats needed to drop lock.

Ports:
- clk  input  1  clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  checker enable; 0 forces IDLE.
- clr_cnt  input  1  synchronous clear of err_cnt and beat_cnt.
- din_vld  input  1  din carries a beat this cycle.
- din  input  WIDTH  data beat; din[WIDTH-1] is the earliest bit in time.
- locked  output  1  checker is in LOCKED.
- err_pulse  output  1  one-cycle strobe after a mismatching beat while LOCKED.
- err_cnt  output  CNT_W  accumulated bit errors while LOCKED; saturating.
- beat_cnt  output  CNT_W  valid beats checked while LOCKED; saturating.

Behaviour:
- Reset (rst=1):
  - state=IDLE; locked=0, err_pulse=0, err_cnt=0, beat_cnt=0.
  - LFSR state S (31 bits), fill counter and run counters all cleared.
  - rst overrides every other input.
- Polynomial x^31+x^28+1.
  - Next bit b = S[30]^S[27]; then S <= {S[29:0], b}.
  - For one beat, W bits b_0..b_{W-1} are generated in order; expected word exp[WIDTH-1-k] = b_k.
- FILL = ceil(31/WIDTH), a local constant.
- States:
  - IDLE: entered on en=0, from any state, on the next edge. Counters hold. When en=1, go to HUNT with fill=0 and match_run=0.
  - HUNT, per valid beat:
    - S shifts in the received bits, din[WIDTH-1] first.
    - While fill<FILL, fill increments and no comparison is made.
    - Once fill==FILL: din==exp and S!=0 increments match_run; otherwise match_run=0.
    - When match_run reaches LOCK_BEATS, go to LOCKED with loss_run=0.
    - An all-zero S never counts as a match. This blocks false lock on a stuck-0 input.
  - LOCKED, per valid beat:
    - S shifts in the predicted bits (flywheel), not din.
    - beat_cnt increments by 1.
    - err_cnt increments by popcount(din^exp).
    - On a mismatch: err_pulse=1 on the next cycle and loss_run increments.
    - On a match: loss_run=0.
    - When loss_run reaches LOSS_BEATS, go to HUNT with fill=0 and match_run=0.
- din_vld=0: no state, LFSR, fill or run change. err_pulse=0.
- Latency: all outputs are registered.
  - locked rises or falls on the edge that consumes the qualifying beat.
  - err_pulse and the counter updates are visible one cycle after the beat.
- Arithmetic:
  - Counters saturate at all-ones and never wrap.
  - err_cnt adds the full popcount, clamped at all-ones.
- Simultaneous events:
  - clr_cnt with an increment: the result is 0 (clear wins).
  - en=0 with a valid beat: the beat is ignored, go to IDLE.
  - Reset mid-lock gives the full reset values.

Decomposition:
- Package prbs_pkg:
  - PRBS_LEN=31, TAP_A=30, TAP_B=27.
  - typedef enum chk_state_t {IDLE, HUNT, LOCKED}.
  - Function prbs31_step(state, WIDTH) returning next state and the expected word.
  - Function popcount.
- One sub-module, sat_counter (parameter CNT_W; inputs clr, inc_en, inc_amt; output cnt). Instantiated twice, for err_cnt and beat_cnt.

Test Plan:
1. Reset: assert rst 2 cycles with din_vld=1 and random din -> locked=0, err_pulse=0, err_cnt=0, beat_cnt=0 throughout and one cycle after.
2. Clean lock: WIDTH=8, en=1, continuous PRBS31 from seed 32'h12345678[30:0] -> locked=1 after beat 8 (FILL 4 + LOCK_BEATS 4). After 100 further beats, beat_cnt=100 and err_cnt=0.
3. Error injection: while locked, flip din[0] on one beat, then flip 3 bits on a later beat -> err_pulse high exactly 2 single cycles, err_cnt=4, locked stays 1.
4. Loss and relock: while locked, drive din=8'h00 for 8 beats -> locked=0 after beat 8. Continue 8'h00 for 20 beats -> no relock. Resume PRBS -> locked=1 after 8 clean beats.
5. Bubbles: same stream as test 2 but din_vld toggling 1/0 -> identical lock beat index, counters and errors. No change on idle cycles.
6. Counters: with CNT_W=4, inject 20 bit errors -> err_cnt=4'hF held. Assert clr_cnt on the same cycle as an error beat -> err_cnt=0 next cycle.
